instr_fetch_ctrl: RTL

- Owns the architectural PC register and drives PCResult to the next-PC adder/branch logic.
- Consumes that logic's PCAddResult as the next fetch address.
- Fetches instructions from instruction memory over a req/ack handshake and buffers them in a small queue for decode.
- Redirect flushes the queue and discards any in-flight fetch; Stall holds off new fetches.

---
 rtl/if_pkg.sv | 16 +
 rtl/instr_fetch_ctrl_if.sv | 29 ++
 rtl/fetch_queue.sv | 59 +++++
 rtl/instr_fetch_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction fetch controller.
// Fetch FSM encoding and bus width / reset PC defaults.
package if_pkg;

    localparam int          ADDR_W_DEF   = 32;
    localparam int          DATA_W_DEF   = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    // IDLE: nothing outstanding, REQ: outstanding and kept, FLUSH: outstanding and dropped
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bundle: next-PC logic, instruction memory handshake and decode queue head.
// master = fetch controller view, slave = surrounding pipeline/memory view.
interface instr_fetch_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] PCAddResult;
    logic              Redirect;
    logic              Stall;
    logic [ADDR_W-1:0] PCResult;
    logic              IMemReq;
    logic [ADDR_W-1:0] IMemAddr;
    logic              IMemAck;
    logic [DATA_W-1:0] IMemData;
    logic              InstrValid;
    logic [DATA_W-1:0] Instr;
    logic [ADDR_W-1:0] InstrPC;
    logic              InstrReady;

    modport master (
        input  PCAddResult, Redirect, Stall, IMemAck, IMemData, InstrReady,
        output PCResult, IMemReq, IMemAddr, InstrValid, Instr, InstrPC
    );

    modport slave (
        output PCAddResult, Redirect, Stall, IMemAck, IMemData, InstrReady,
        input  PCResult, IMemReq, IMemAddr, InstrValid, Instr, InstrPC
    );
endinterface

// File: rtl/fetch_queue.sv
// DEPTH-entry FIFO of {pc, instr}; head is combinational from storage, push/pop one cycle.
// No internal backpressure: caller guarantees no push when full; clear wins over push/pop.
module fetch_queue #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              clear_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [DATA_W-1:0] instr_i,
    output logic [ADDR_W-1:0] head_pc_o,
    output logic [DATA_W-1:0] head_instr_o,
    output logic [CNT_W-1:0]  count_o
);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [PW-1:0]     rd_q;
    logic [PW-1:0]     wr_q;
    logic [CNT_W-1:0]  cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (clear_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + PW'(1);
            if (pop_i)  rd_q <= rd_q + PW'(1);
            cnt_q <= cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) begin
            mem_q[wr_q] <= '{pc: pc_i, instr: instr_i};
        end
    end

    assign head_pc_o    = mem_q[rd_q].pc;
    assign head_instr_o = mem_q[rd_q].instr;
    assign count_o      = cnt_q;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// PC owner and instruction fetcher: one outstanding req/ack fetch into a DEPTH-entry decode queue.
// Registered request one cycle after issue decision; Stall and queue space hold off new issues only.
module instr_fetch_ctrl
    import if_pkg::*;
#(
    parameter int              ADDR_W   = ADDR_W_DEF,
    parameter int              DATA_W   = DATA_W_DEF,
    parameter int              DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic               Clk,
    input  logic               Rst,
    instr_fetch_ctrl_if.master bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              push;
    logic              pop;
    logic              clear;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic              space;

    // Redirect drops any returning data, so only a kept ack ever pushes.
    assign push      = (state_q == REQ) && bus.IMemAck && !bus.Redirect;
    assign pop       = bus.InstrValid && bus.InstrReady;
    assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);
    assign space     = count_nxt < CNT_W'(DEPTH);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        addr_d  = addr_q;
        clear   = 1'b0;

        if (bus.Redirect) begin
            clear = 1'b1;
            pc_d  = bus.PCAddResult;
            if (state_q != IDLE) begin
                // An unacked request cannot be withdrawn; wait it out in FLUSH.
                if (bus.IMemAck) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end else begin
                    state_d = FLUSH;
                end
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (!bus.Stall && space) begin
                        state_d = REQ;
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                    end
                end
                REQ: begin
                    if (bus.IMemAck) begin
                        pc_d = bus.PCAddResult;
                        if (!bus.Stall && space) begin
                            addr_d = bus.PCAddResult;
                        end else begin
                            state_d = IDLE;
                            req_d   = 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    if (bus.IMemAck) begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    fetch_queue #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_queue (
        .clk_i        (Clk),
        .rst_ni       (Rst),
        .push_i       (push),
        .pop_i        (pop),
        .clear_i      (clear),
        .pc_i         (pc_q),
        .instr_i      (bus.IMemData),
        .head_pc_o    (bus.InstrPC),
        .head_instr_o (bus.Instr),
        .count_o      (count)
    );

    assign bus.PCResult   = pc_q;
    assign bus.IMemReq    = req_q;
    assign bus.IMemAddr   = addr_q;
    assign bus.InstrValid = (count != '0);

endmodule
